// File: rtl/gate_input_debouncer.sv
// Two-channel synchroniser + debouncer feeding the logic-gate demo inputs.
// Each channel accepts a new level only after it holds for DEBOUNCE_CYCLES cycles.
module gate_input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic in1,
  output logic in2,
  output logic in1_chg,
  output logic in2_chg
);

  localparam int unsigned NCH = 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0]       w_raw;
  logic [NCH-1:0]       r_s0;
  logic [NCH-1:0]       r_s1;
  logic [NCH-1:0]       r_level;
  logic [NCH-1:0]       r_chg;
  logic [CNT_WIDTH-1:0] r_cnt [NCH];

  logic [NCH-1:0]       w_pending;
  logic [NCH-1:0]       w_accept;
  logic [NCH-1:0]       w_level_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt [NCH];

  assign w_raw = {btn2_raw, btn1_raw};

  // State register: synchroniser, counters, accepted levels and change pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0    <= '0;
      r_s1    <= '0;
      r_level <= '0;
      r_chg   <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        r_cnt[ch] <= '0;
      end
    end else begin
      r_s0    <= w_raw;
      r_s1    <= r_s0;
      r_level <= w_level_nxt;
      r_chg   <= w_accept;
      for (int ch = 0; ch < NCH; ch++) begin
        r_cnt[ch] <= w_cnt_nxt[ch];
      end
    end
  end

  // Next state: PENDING while the synchronised input disagrees with the level;
  // any agreeing cycle (bounce) drops back to STABLE and clears the count.
  always_comb begin
    w_pending   = '0;
    w_accept    = '0;
    w_level_nxt = r_level;
    for (int ch = 0; ch < NCH; ch++) begin
      w_cnt_nxt[ch] = '0;
      w_pending[ch] = r_s1[ch] != r_level[ch];
      if (w_pending[ch]) begin
        if (r_cnt[ch] == CNT_LAST) begin
          w_accept[ch]    = 1'b1;
          w_level_nxt[ch] = r_s1[ch];
        end else begin
          w_cnt_nxt[ch] = r_cnt[ch] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    in1     = r_level[0];
    in2     = r_level[1];
    in1_chg = r_chg[0];
    in2_chg = r_chg[1];
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed bench for gate_input_debouncer with DEBOUNCE_CYCLES=4.
// Expected vectors are {in1, in2, in1_chg, in2_chg} after each rising edge.
module tb_gate_input_debouncer;

  logic clk;
  logic rst;
  logic btn1_raw;
  logic btn2_raw;
  logic in1;
  logic in2;
  logic in1_chg;
  logic in2_chg;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       rst;
    logic       b1;
    logic       b2;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  gate_input_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn1_raw(btn1_raw),
    .btn2_raw(btn2_raw),
    .in1(in1),
    .in2(in2),
    .in1_chg(in1_chg),
    .in2_chg(in2_chg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic b1, input logic b2,
                              input int n, input logic [3:0] e, input string nm);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.rst  = r;
      v.b1   = b1;
      v.b2   = b2;
      v.exp  = e;
      v.name = nm;
      vecs.push_back(v);
    end
  endfunction

  // Drive inputs, clock once, compare outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic b1, input logic b2,
                      input logic [3:0] e, input string nm);
    logic [3:0] got;
    rst      = r;
    btn1_raw = b1;
    btn2_raw = b2;
    @(posedge clk);
    #1;
    got = {in1, in2, in1_chg, in2_chg};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s @%0t: {in1,in2,in1_chg,in2_chg} got %b expected %b",
               nm, $time, got, e);
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    btn1_raw = 1'b0;
    btn2_raw = 1'b0;

    // Reset held with both buttons high, then release: rise on 6th free edge.
    add(1, 1, 1, 3, 4'b0000, "reset_hold");
    add(0, 1, 1, 5, 4'b0000, "post_reset_wait");
    add(0, 1, 1, 1, 4'b1111, "post_reset_rise");
    // Both fall back to 0.
    add(0, 0, 0, 1, 4'b1100, "fall_both_pulse_clear");
    add(0, 0, 0, 4, 4'b1100, "fall_both_wait");
    add(0, 0, 0, 1, 4'b0011, "fall_both_edge");
    // Clean rise on channel 1 only.
    add(0, 1, 0, 5, 4'b0000, "clean_rise_wait");
    add(0, 1, 0, 1, 4'b1010, "clean_rise_edge");
    add(0, 1, 0, 1, 4'b1000, "clean_rise_after");
    // Three-cycle glitch on channel 2 must be rejected.
    add(0, 1, 1, 3, 4'b1000, "glitch2_high");
    add(0, 1, 0, 6, 4'b1000, "glitch2_low");
    // Return channel 1 to 0, then simultaneous rise and fall.
    add(0, 0, 0, 5, 4'b1000, "ch1_fall_wait");
    add(0, 0, 0, 1, 4'b0010, "ch1_fall_edge");
    add(0, 1, 1, 5, 4'b0000, "simul_rise_wait");
    add(0, 1, 1, 1, 4'b1111, "simul_rise_edge");
    add(0, 0, 0, 5, 4'b1100, "simul_fall_wait");
    add(0, 0, 0, 1, 4'b0011, "simul_fall_edge");
    add(0, 0, 0, 1, 4'b0000, "simul_fall_after");

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].b1, vecs[i].b2, vecs[i].exp, vecs[i].name);
    end

    // Bounce: 1,1,0,0,1,1,0,0 then hold 1; accepted 5 edges after final rise.
    for (int i = 0; i < 8; i++) begin
      step(0, ((i / 2) % 2) == 0, 0, 4'b0000, "bounce_toggle");
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'b0000, "bounce_settle");
    end
    step(0, 1, 0, 4'b1010, "bounce_accept");
    step(0, 1, 0, 4'b1000, "bounce_single_pulse");
    step(0, 1, 0, 4'b1000, "bounce_hold");

    // Drop channel 1 back to 0 for the reset-mid-debounce case.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 4'b1000, "pre_rst_fall_wait");
    end
    step(0, 0, 0, 4'b0010, "pre_rst_fall_edge");

    // Rise interrupted by reset at E+3; restart from an empty synchroniser.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 4'b0000, "mid_rst_pending");
    end
    step(1, 1, 0, 4'b0000, "mid_rst_pulse");
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 4'b0000, "mid_rst_refill");
    end
    step(0, 1, 0, 4'b1010, "mid_rst_accept");
    step(0, 1, 0, 4'b1000, "mid_rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
